// File: rtl/ram_scan_display_if.sv
// Bus bundle for ram_scan_display: write port, read-mode controls and
// read-back/status signals. The master drives stimulus; the slave is the RAM.
interface ram_scan_display_if #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 5
) ();
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mode_scan;
  logic [ADDR_W-1:0] man_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;

  modport master (
    output wr_req, wr_addr, wr_data, mode_scan, man_addr,
    input  rd_addr, rd_data, busy
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, mode_scan, man_addr,
    output rd_addr, rd_data, busy
  );
endinterface

// File: rtl/ram_scan_display.sv
// On-chip RAM that self-clears after reset, writes on a strobe rising edge and
// reads either a manual address or an auto-scanning address for display.
module ram_scan_display #(
  parameter int DATA_W   = 3,
  parameter int ADDR_W   = 5,
  parameter int SCAN_DIV = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  ram_scan_display_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] clr_addr_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic              wr_req_d_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              busy_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              wr_fire_s;

  // User write fires only on a fresh strobe edge once the clear has finished
  always_comb begin
    wr_fire_s = 1'b0;
    if ((state_r == ST_RUN) && bus.wr_req && !wr_req_d_r) begin
      wr_fire_s = 1'b1;
    end else begin
      wr_fire_s = 1'b0;
    end
  end

  // Memory array: cleared word-by-word in CLEAR, user-written in RUN
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[clr_addr_r] <= {DATA_W{1'b0}};
    end else if (wr_fire_s) begin
      mem_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Control FSM, strobe history, read address/data and busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_CLEAR;
      clr_addr_r <= {ADDR_W{1'b0}};
      div_cnt_r  <= {DIV_W{1'b0}};
      wr_req_d_r <= 1'b0;
      rd_addr_r  <= {ADDR_W{1'b0}};
      rd_data_r  <= {DATA_W{1'b0}};
      busy_r     <= 1'b1;
    end else begin
      wr_req_d_r <= bus.wr_req;
      case (state_r)
        ST_CLEAR: begin
          clr_addr_r <= clr_addr_r + ADDR_W'(1);
          div_cnt_r  <= {DIV_W{1'b0}};
          rd_addr_r  <= {ADDR_W{1'b0}};
          rd_data_r  <= {DATA_W{1'b0}};
          // Last word written this cycle: busy drops with the move to RUN
          if (clr_addr_r == ADDR_LAST) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          busy_r    <= 1'b0;
          rd_data_r <= mem_r[rd_addr_r];
          if (!bus.mode_scan) begin
            rd_addr_r <= bus.man_addr;
            div_cnt_r <= {DIV_W{1'b0}};
          end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DIV_W{1'b0}};
            rd_addr_r <= rd_addr_r + ADDR_W'(1);
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        default: begin
          state_r    <= ST_CLEAR;
          clr_addr_r <= {ADDR_W{1'b0}};
          div_cnt_r  <= {DIV_W{1'b0}};
          rd_addr_r  <= {ADDR_W{1'b0}};
          rd_data_r  <= {DATA_W{1'b0}};
          busy_r     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rd_addr = rd_addr_r;
  assign bus.rd_data = rd_data_r;
  assign bus.busy    = busy_r;
endmodule

// File: tb/tb_ram_scan_display.sv
// Self-checking bench for ram_scan_display: a memory model feeds an expected
// queue that is popped as the registered read data emerges.
module tb_ram_scan_display;
  localparam int DATA_W   = 3;
  localparam int ADDR_W   = 5;
  localparam int SCAN_DIV = 4;
  localparam int DEPTH    = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  ram_scan_display_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_scan_display #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Releases reset and counts cycles with busy high (bounded)
  task automatic release_and_count(output int cyc);
    reset = 1'b1;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
    clear_model();
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_req  = 1'b1;
    tick();
    bus.wr_req  = 1'b0;
    tick();
    model[a] = d;
  endtask

  // Manual reads of a contiguous range, scoreboarded with 2-cycle latency
  task automatic read_range(input int start, input int count);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] e;
    exp_q.delete();
    for (int i = 0; i <= count; i++) begin
      a = ADDR_W'(start + i);
      if (i < count) begin
        bus.man_addr = a;
        exp_q.push_back(model[a]);
      end
      tick();
      if (i < count) begin
        n_cmp++;
        if (bus.rd_addr !== a) begin
          n_fail++;
          $display("FAIL read_addr: got %0h expected %0h", bus.rd_addr, a);
        end
      end
      if (i >= 1) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.rd_data !== e) begin
          n_fail++;
          $display("FAIL read_data addr %0h: got %0h expected %0h",
                   ADDR_W'(start + i - 1), bus.rd_data, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.mode_scan = 1'b0; bus.man_addr = '0;
    reset = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %0b expected 1", bus.busy); end
    n_cmp++;
    if (bus.rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0h expected 0", bus.rd_addr); end
    n_cmp++;
    if (bus.rd_data !== 3'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0h expected 0", bus.rd_data); end
    release_and_count(cyc);
    n_cmp++;
    if (cyc != 32) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d expected 32", cyc); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_clear: got %0b expected 0", bus.busy); end
    read_range(0, DEPTH);
  endtask

  task automatic test_write_read();
    do_write(5'h13, 3'd5);
    bus.man_addr = 5'h00;
    tick(); tick();
    exp_q.delete();
    bus.man_addr = 5'h13;
    exp_q.push_back(model[0]);
    exp_q.push_back(3'd5);
    tick();
    n_cmp++;
    if (bus.rd_data !== exp_q.pop_front()) begin n_fail++; $display("FAIL latency_old: got %0h expected %0h", bus.rd_data, model[0]); end
    tick();
    n_cmp++;
    if (bus.rd_data !== exp_q.pop_front()) begin n_fail++; $display("FAIL latency_new: got %0h expected 5", bus.rd_data); end
    read_range(32'h12, 2);
  endtask

  task automatic test_read_during_write();
    do_write(5'd9, 3'd2);
    bus.man_addr = 5'd9;
    tick(); tick();
    exp_q.delete();
    bus.wr_addr = 5'd9; bus.wr_data = 3'd6; bus.wr_req = 1'b1;
    exp_q.push_back(model[9]);
    exp_q.push_back(3'd6);
    model[9] = 3'd6;
    tick();
    bus.wr_req = 1'b0;
    n_cmp++;
    if (bus.rd_data !== exp_q.pop_front()) begin n_fail++; $display("FAIL rdw_old: got %0h expected 2", bus.rd_data); end
    tick();
    n_cmp++;
    if (bus.rd_data !== exp_q.pop_front()) begin n_fail++; $display("FAIL rdw_new: got %0h expected 6", bus.rd_data); end
  endtask

  task automatic test_held_strobe();
    int cyc;
    bus.wr_addr = 5'd3; bus.wr_data = 3'd7; bus.wr_req = 1'b1;
    reset = 1'b0;
    repeat (3) tick();
    release_and_count(cyc);
    n_cmp++;
    if (cyc != 32) begin n_fail++; $display("FAIL held_busy_cycles: got %0d expected 32", cyc); end
    read_range(3, 1);
    repeat (10) tick();
    read_range(3, 1);
    bus.wr_req = 1'b0;
    tick();
    bus.wr_req = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    tick();
    model[3] = 3'd7;
    read_range(2, 3);
  endtask

  task automatic test_scan_wrap();
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] e;
    for (int a = 0; a < DEPTH; a++) do_write(ADDR_W'(a), DATA_W'(a % 8));
    bus.man_addr = 5'd0;
    tick(); tick();
    exp_q.delete();
    exp_q.push_back(model[0]);
    bus.mode_scan = 1'b1;
    for (int j = 1; j <= 4 * (DEPTH + 1) + 4; j++) begin
      tick();
      ea = ADDR_W'((j / SCAN_DIV) % DEPTH);
      n_cmp++;
      if (bus.rd_addr !== ea) begin n_fail++; $display("FAIL scan_addr cyc %0d: got %0h expected %0h", j, bus.rd_addr, ea); end
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.rd_data !== e) begin n_fail++; $display("FAIL scan_data cyc %0d: got %0h expected %0h", j, bus.rd_data, e); end
      exp_q.push_back(model[ea]);
    end
    bus.mode_scan = 1'b0;
    bus.man_addr  = 5'd7;
    tick();
    n_cmp++;
    if (bus.rd_addr !== 5'd7) begin n_fail++; $display("FAIL scan_to_manual: got %0h expected 7", bus.rd_addr); end
    tick();
    n_cmp++;
    if (bus.rd_data !== model[7]) begin n_fail++; $display("FAIL scan_to_manual_data: got %0h expected %0h", bus.rd_data, model[7]); end
  endtask

  task automatic test_reset_mid_clear();
    int cyc;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.rd_addr !== 5'd0 || bus.rd_data !== 3'd0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_run: got addr %0h data %0h busy %0b expected 0 0 1",
               bus.rd_addr, bus.rd_data, bus.busy);
    end
    tick(); tick();
    reset = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_clear_busy: got %0b expected 1", bus.busy); end
    reset = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    release_and_count(cyc);
    n_cmp++;
    if (cyc != 32) begin n_fail++; $display("FAIL reclear_busy_cycles: got %0d expected 32", cyc); end
    read_range(0, DEPTH);
  endtask

  initial begin
    reset = 1'b0;
    clear_model();
    test_reset();
    test_write_read();
    test_read_during_write();
    test_held_strobe();
    test_scan_wrap();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
